// File: rtl/flag_update_if.sv
// Purpose : NZCV producer/consumer bus between the EX stage and flag_update_unit.
// Signals : EX-stage capture inputs (valid_i, s_i, cond_pass_i, stall_i, flush_i,
//           exe_cmd_i, result_i, alu_c_i, alu_v_i, shift_c_i), direct status-register
//           write (sr_wr_en_i, sr_wr_data_i) and flag outputs (sr_o, sr_eff_o,
//           flags_pending_o).
// Modports: master = pipeline side driving the inputs, slave = flag_update_unit.
interface flag_update_if #(
  parameter int unsigned DATA_W = 32
);
  logic              valid_i;
  logic              s_i;
  logic              cond_pass_i;
  logic              stall_i;
  logic              flush_i;
  logic [3:0]        exe_cmd_i;
  logic [DATA_W-1:0] result_i;
  logic              alu_c_i;
  logic              alu_v_i;
  logic              shift_c_i;
  logic              sr_wr_en_i;
  logic [3:0]        sr_wr_data_i;
  logic [3:0]        sr_o;
  logic [3:0]        sr_eff_o;
  logic              flags_pending_o;

  modport master (
    output valid_i, s_i, cond_pass_i, stall_i, flush_i, exe_cmd_i, result_i,
           alu_c_i, alu_v_i, shift_c_i, sr_wr_en_i, sr_wr_data_i,
    input  sr_o, sr_eff_o, flags_pending_o
  );

  modport slave (
    input  valid_i, s_i, cond_pass_i, stall_i, flush_i, exe_cmd_i, result_i,
           alu_c_i, alu_v_i, shift_c_i, sr_wr_en_i, sr_wr_data_i,
    output sr_o, sr_eff_o, flags_pending_o
  );
endinterface

// File: rtl/flag_update_unit.sv
// Purpose : Computes NZCV from the EX-stage ALU result, stages it for one cycle and
//           commits it to the architectural status register. A direct write from
//           the MSR/exception-restore path overrides a staged commit.
// Ports   : clk, rst_n (async active-low), bus (flag_update_if.slave):
//           inputs  valid_i, s_i, cond_pass_i, stall_i, flush_i, exe_cmd_i,
//                   result_i, alu_c_i, alu_v_i, shift_c_i, sr_wr_en_i, sr_wr_data_i
//           outputs sr_o (committed {N,Z,C,V}), sr_eff_o (flags for condition
//                   check), flags_pending_o (staged update not yet committed)
// Options : FLAG_FORWARD_EN - when defined, sr_eff_o forwards the staged flags;
//           otherwise sr_eff_o is the committed register.
module flag_update_unit #(
  parameter int unsigned DATA_W = 32,
  parameter logic [3:0]  SR_RST = 4'b0000
) (
  input logic         clk,
  input logic         rst_n,
  flag_update_if.slave bus
);

  localparam int unsigned FLAG_W  = 4;
  localparam logic [3:0]  CMD_ADD = 4'b0010;
  localparam logic [3:0]  CMD_ADC = 4'b0011;
  localparam logic [3:0]  CMD_SUB = 4'b0100;
  localparam logic [3:0]  CMD_SBC = 4'b0101;

  logic [FLAG_W-1:0] r_sr;
  logic              r_pend_vld;
  logic [FLAG_W-1:0] r_pend_nzcv;

  logic              w_cap;
  logic              w_arith;
  logic              w_eff_v;
  logic [FLAG_W-1:0] w_nzcv;

  assign w_cap = bus.valid_i & bus.s_i & bus.cond_pass_i & ~bus.stall_i & ~bus.flush_i;

  assign w_arith = (bus.exe_cmd_i == CMD_ADD) || (bus.exe_cmd_i == CMD_ADC) ||
                   (bus.exe_cmd_i == CMD_SUB) || (bus.exe_cmd_i == CMD_SBC);

  // Logical ops keep V; the in-flight staged value is newer than the committed one.
  assign w_eff_v = r_pend_vld ? r_pend_nzcv[0] : r_sr[0];

  // New flags {N,Z,C,V}
  always_comb begin
    w_nzcv    = '0;
    w_nzcv[3] = bus.result_i[DATA_W-1];
    w_nzcv[2] = (bus.result_i == '0);
    w_nzcv[1] = w_arith ? bus.alu_c_i : bus.shift_c_i;
    w_nzcv[0] = w_arith ? bus.alu_v_i : w_eff_v;
  end

  // Stage register: each capture occupies the stage for exactly one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_vld  <= 1'b0;
      r_pend_nzcv <= '0;
    end else begin
      r_pend_vld <= w_cap;
      if (w_cap) begin
        r_pend_nzcv <= w_nzcv;
      end
    end
  end

  // Commit: direct write wins over a staged update, which is then dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr <= SR_RST;
    end else if (bus.sr_wr_en_i) begin
      r_sr <= bus.sr_wr_data_i;
    end else if (r_pend_vld) begin
      r_sr <= r_pend_nzcv;
    end
  end

  assign bus.sr_o            = r_sr;
  assign bus.flags_pending_o = r_pend_vld;

`ifdef FLAG_FORWARD_EN
  assign bus.sr_eff_o = r_pend_vld ? r_pend_nzcv : r_sr;
`else
  assign bus.sr_eff_o = r_sr;
`endif

endmodule

// File: tb/tb_flag_update_unit.sv
module tb_flag_update_unit;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_err;

  flag_update_if #(.DATA_W(32)) bus ();

  flag_update_unit #(.DATA_W(32), .SR_RST(4'b0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.valid_i      = 1'b0;
    bus.s_i          = 1'b0;
    bus.cond_pass_i  = 1'b0;
    bus.stall_i      = 1'b0;
    bus.flush_i      = 1'b0;
    bus.exe_cmd_i    = 4'b0000;
    bus.result_i     = 32'h0;
    bus.alu_c_i      = 1'b0;
    bus.alu_v_i      = 1'b0;
    bus.shift_c_i    = 1'b0;
    bus.sr_wr_en_i   = 1'b0;
    bus.sr_wr_data_i = 4'b0000;
  endtask

  task automatic issue(input logic [3:0] cmd, input logic [31:0] res,
                       input logic c, input logic v, input logic sc);
    bus.valid_i     = 1'b1;
    bus.s_i         = 1'b1;
    bus.cond_pass_i = 1'b1;
    bus.exe_cmd_i   = cmd;
    bus.result_i    = res;
    bus.alu_c_i     = c;
    bus.alu_v_i     = v;
    bus.shift_c_i   = sc;
  endtask

  // Settle just after the active edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected sr_eff_o: forwarded stage value or committed value depending on build
  function automatic logic [3:0] eff(input logic [3:0] staged, input logic [3:0] committed);
`ifdef FLAG_FORWARD_EN
    return staged;
`else
    return committed;
`endif
  endfunction

  initial begin
    n_checks = 0;
    n_err    = 0;
    idle();
    rst_n = 1'b0;
    #2;
    chk("reset_sr", bus.sr_o, 4'b0000);
    chk("reset_pend", {3'b0, bus.flags_pending_o}, 4'b0000);
    chk("reset_eff", bus.sr_eff_o, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;

    // SUB result 0, carry 1 -> 0110
    @(negedge clk);
    issue(4'b0100, 32'h0, 1'b1, 1'b0, 1'b0);
    step();
    chk("sub_pend", {3'b0, bus.flags_pending_o}, 4'b0001);
    chk("sub_sr_before", bus.sr_o, 4'b0000);
    chk("sub_eff", bus.sr_eff_o, eff(4'b0110, 4'b0000));
    @(negedge clk);
    idle();
    step();
    chk("sub_commit", bus.sr_o, 4'b0110);
    chk("sub_pend_clr", {3'b0, bus.flags_pending_o}, 4'b0000);

    // Direct write sr=0001, then AND 0x80000000 shift_c 1 -> 1011 (V kept)
    @(negedge clk);
    bus.sr_wr_en_i   = 1'b1;
    bus.sr_wr_data_i = 4'b0001;
    step();
    chk("wr_0001", bus.sr_o, 4'b0001);
    @(negedge clk);
    idle();
    issue(4'b0000, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
    step();
    @(negedge clk);
    idle();
    step();
    chk("logic_commit", bus.sr_o, 4'b1011);

    // Suppression: cond fail, stall, flush
    @(negedge clk);
    issue(4'b0010, 32'h0, 1'b0, 1'b0, 1'b0);
    bus.cond_pass_i = 1'b0;
    step();
    chk("sup_cond_pend", {3'b0, bus.flags_pending_o}, 4'b0000);
    @(negedge clk);
    bus.cond_pass_i = 1'b1;
    bus.stall_i     = 1'b1;
    step();
    chk("sup_stall_pend", {3'b0, bus.flags_pending_o}, 4'b0000);
    @(negedge clk);
    bus.stall_i = 1'b0;
    bus.flush_i = 1'b1;
    step();
    chk("sup_flush_pend", {3'b0, bus.flags_pending_o}, 4'b0000);
    chk("sup_sr", bus.sr_o, 4'b1011);

    // Collision: staged 1000, direct write 0011 wins
    @(negedge clk);
    idle();
    issue(4'b0010, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
    step();
    chk("col_pend", {3'b0, bus.flags_pending_o}, 4'b0001);
    @(negedge clk);
    idle();
    bus.sr_wr_en_i   = 1'b1;
    bus.sr_wr_data_i = 4'b0011;
    step();
    chk("col_sr", bus.sr_o, 4'b0011);
    chk("col_pend_clr", {3'b0, bus.flags_pending_o}, 4'b0000);
    @(negedge clk);
    idle();
    step();
    chk("col_dropped", bus.sr_o, 4'b0011);

    // Direct write 0101 with same-cycle capture ADD result 1 c1 v1 -> 0011 later
    @(negedge clk);
    issue(4'b0010, 32'h1, 1'b1, 1'b1, 1'b0);
    bus.sr_wr_en_i   = 1'b1;
    bus.sr_wr_data_i = 4'b0101;
    step();
    chk("wrcap_sr", bus.sr_o, 4'b0101);
    chk("wrcap_pend", {3'b0, bus.flags_pending_o}, 4'b0001);
    @(negedge clk);
    idle();
    step();
    chk("wrcap_commit", bus.sr_o, 4'b0011);

    // Back-to-back: ADD->0100, SUB->1011, AND (V from staged)->0001
    @(negedge clk);
    issue(4'b0010, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    chk("b2b1_pend", {3'b0, bus.flags_pending_o}, 4'b0001);
    chk("b2b1_sr", bus.sr_o, 4'b0011);
    chk("fwd_adds_eff", bus.sr_eff_o, eff(4'b0100, 4'b0011));
    @(negedge clk);
    issue(4'b0100, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0);
    step();
    chk("b2b2_pend", {3'b0, bus.flags_pending_o}, 4'b0001);
    chk("b2b2_sr", bus.sr_o, 4'b0100);
    @(negedge clk);
    issue(4'b0000, 32'h5, 1'b1, 1'b0, 1'b0);
    step();
    chk("b2b3_pend", {3'b0, bus.flags_pending_o}, 4'b0001);
    chk("b2b3_sr", bus.sr_o, 4'b1011);
    chk("b2b3_eff", bus.sr_eff_o, eff(4'b0001, 4'b1011));
    @(negedge clk);
    idle();
    step();
    chk("b2b_final", bus.sr_o, 4'b0001);
    chk("b2b_pend_clr", {3'b0, bus.flags_pending_o}, 4'b0000);

    // Mid-cycle reset with a staged 1000 update
    @(negedge clk);
    issue(4'b0010, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
    step();
    chk("rst_pre_pend", {3'b0, bus.flags_pending_o}, 4'b0001);
    idle();
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_sr", bus.sr_o, 4'b0000);
    chk("rst_mid_pend", {3'b0, bus.flags_pending_o}, 4'b0000);
    chk("rst_mid_eff", bus.sr_eff_o, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("rst_never_commit", bus.sr_o, 4'b0000);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/flag_update_unit.md
Name: flag_update_unit

Overview:
- Producer side of the NZCV status interface consumed by the condition-check logic.
- Takes the EX-stage ALU result and carry/overflow, computes new N, Z, C, V, stages them for one cycle, then commits them to the architectural status register.
- Exports the committed flags, a pending indication for the hazard unit, and an effective-flags view for the condition checker.
- Also accepts a direct status-register write from the MSR/exception-restore path.

Parameters:
- DATA_W, 32, width of the ALU result.
- SR_RST, 4'b0000, reset value of the committed status register {N,Z,C,V}.

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- valid_i  in  1  EX-stage instruction valid.
- s_i  in  1  S bit: instruction updates flags.
- cond_pass_i  in  1  instruction condition passed (from condition check).
- stall_i  in  1  EX stage frozen this cycle.
- flush_i  in  1  EX-stage instruction is being squashed.
- exe_cmd_i  in  4  ALU command code.
- result_i  in  DATA_W  ALU result.
- alu_c_i  in  1  ALU adder carry out.
- alu_v_i  in  1  ALU adder overflow.
- shift_c_i  in  1  shifter carry out.
- sr_wr_en_i  in  1  direct status-register write strobe.
- sr_wr_data_i  in  4  direct write value {N,Z,C,V}.
- sr_o  out  4  committed status register {N,Z,C,V}; bit 3 = N, bit 2 = Z, bit 1 = C, bit 0 = V.
- sr_eff_o  out  4  flags the condition checker must use.
- flags_pending_o  out  1  staged flag update not yet committed.

Behaviour:
- Reset (rst_n low, asynchronous): sr = SR_RST, pend_vld = 0, pend_nzcv = 0. Therefore sr_o = SR_RST, flags_pending_o = 0, sr_eff_o = SR_RST.
- Capture condition: cap = valid_i & s_i & cond_pass_i & ~stall_i & ~flush_i.
- Flag computation:
  - N = result_i[DATA_W-1].
  - Z = (result_i == 0).
  - Arithmetic commands (exe_cmd_i 4'b0010 ADD, 4'b0011 ADC, 4'b0100 SUB, 4'b0101 SBC): C = alu_c_i, V = alu_v_i.
  - All other commands (logical/move): C = shift_c_i, V = the currently effective V.
  - "Effective" means pend_nzcv[0] if pend_vld, else sr[0].
- Stage register, per rising edge:
  - pend_vld <= cap; pend_nzcv <= computed flags when cap, otherwise held.
  - Each capture occupies the stage for exactly one cycle.
- Commit, per rising edge:
  - If sr_wr_en_i: sr <= sr_wr_data_i.
  - Else if pend_vld: sr <= pend_nzcv.
  - Else sr holds.
- Simultaneous direct write and pending commit: the direct write wins and the staged value is discarded.
- A capture in the same cycle is still staged normally and commits on the following edge, overwriting the direct write.
- Back-to-back captures: each commits in order one cycle after capture, with no bubble. flags_pending_o stays high for the whole run.
- stall_i and flush_i block capture only; an already-staged update always commits.
- Latency: capture at edge k, sr_o updated at edge k+1.
- flags_pending_o = pend_vld (registered).
- Reset asserted mid-operation clears any staged update immediately; it is never committed.

Optional Feature:
- Macro: FLAG_FORWARD_EN.
- Defined: sr_eff_o = pend_vld ? pend_nzcv : sr. This bypasses the staged flags, so the hazard unit need not stall on flags_pending_o.
- Undefined: sr_eff_o = sr. The hazard unit must stall any conditional instruction while flags_pending_o = 1.
- sr_o and flags_pending_o are identical in both builds.

Test Plan:
- Reset: drive rst_n low mid-cycle with pend_vld = 1 -> sr_o = 0000 and flags_pending_o = 0 immediately; staged value never appears.
- SUB capture: exe_cmd 0100, result 0, alu_c 1, alu_v 0, s = 1, cond_pass = 1 -> flags_pending_o = 1 next cycle, sr_o = 0110 one cycle later.
- Logical update: sr = 0001, AND with result 0x80000000, shift_c 1 -> sr_o = 1011 (V preserved).
- Suppression: s = 1 with cond_pass = 0, or with stall_i = 1, or with flush_i = 1 (each a separate cycle) -> no pending update, sr_o unchanged.
- Collision: pend_vld = 1 with pend = 1000, sr_wr_en_i = 1 with data 0011 -> sr_o = 0011, staged value dropped.
- Forwarding: ADDS producing 0100 -> the cycle after capture, sr_eff_o = 0100 with FLAG_FORWARD_EN defined; without it, sr_eff_o = old sr until commit.
